// File: rtl/rev_unmux12_seq.sv
// Bit-serial reversible (un)multiplexer: applies A[i]^=S&X[i], B[i]^=~S&X[i] one gate per clock,
// in forward (dir=0) or exact reverse (dir=1) order, so a forward pass can be uncomputed cleanly.
`timescale 1ns/1ps
module rev_unmux12_seq #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             dir,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             s_in,
    input  logic [WIDTH-1:0] x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             s_out,
    output logic [WIDTH-1:0] x_out,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STG1 = 2'd1,
        STG2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             s_q, s_d;
    logic             dir_q, dir_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Forward order walks bits upward while idx counts down; reverse order uses idx directly.
    logic [IDX_W-1:0] pos_asc;
    logic [WIDTH-1:0] mask_fwd, mask_rev;
    logic [WIDTH-1:0] s_rep;

    function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] pos);
        bit_mask = WIDTH'(1) << pos;
    endfunction

    assign pos_asc  = IDX_MAX - idx_q;
    assign mask_fwd = bit_mask(pos_asc);
    assign mask_rev = bit_mask(idx_q);
    assign s_rep    = {WIDTH{s_q}};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        s_d     = s_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    x_d     = x_in;
                    s_d     = s_in;
                    dir_d   = dir;
                    idx_d   = IDX_MAX;
                    state_d = STG1;
                end
            end
            STG1: begin
                if (!dir_q) begin
                    a_d = a_q ^ (mask_fwd & x_q & s_rep);
                end else begin
                    b_d = b_q ^ (mask_rev & x_q & ~s_rep);
                end
                if (idx_q == '0) begin
                    idx_d   = IDX_MAX;
                    state_d = STG2;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            STG2: begin
                if (!dir_q) begin
                    b_d = b_q ^ (mask_fwd & x_q & ~s_rep);
                end else begin
                    a_d = a_q ^ (mask_rev & x_q & s_rep);
                end
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                // Returning to IDLE wins over a simultaneous in_valid; the next accept is one edge later.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            s_q     <= 1'b0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            s_q     <= s_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == STG1) | (state_q == STG2);
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign s_out     = s_q;
    assign x_out     = x_q;

endmodule

// File: tb/tb_rev_unmux12_seq.sv
// Scoreboard bench for rev_unmux12_seq: expected words queued at accept, checked at out_valid.
`timescale 1ns/1ps
module tb_rev_unmux12_seq;
    localparam int W = 12;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         dir;
    logic [W-1:0] a_in, b_in, x_in;
    logic         s_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a_out, b_out, x_out;
    logic         s_out;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] x;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rev_unmux12_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .dir(dir),
        .a_in(a_in), .b_in(b_in), .s_in(s_in), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .s_out(s_out), .x_out(x_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand set at a falling edge; the following rising edge is the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input logic [W-1:0] x, input logic d);
        res_t e;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_ready: got %b expected 1", in_ready);
        end
        in_valid = 1'b1; a_in = a; b_in = b; s_in = s; x_in = x; dir = d;
        e.a = a ^ (x & {W{s}});
        e.b = b ^ (x & ~{W{s}});
        e.s = s;
        e.x = x;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); x_in = W'($urandom);
        s_in = 1'($urandom); dir = 1'($urandom);
    endtask

    // Wait for the result, optionally check an intermediate A/B trace point, inject an in_valid pulse,
    // hold in DONE, then release with out_ready.
    task automatic finish_op(input int trace_step, input logic [2*W-1:0] trace_ab,
                             input int pulse_at, input int hold);
        int   cycles;
        res_t e;
        logic [3*W:0] snap;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (cycles == pulse_at) begin
                in_valid = 1'b1; a_in = 12'hFFF; b_in = 12'hFFF; x_in = 12'hFFF; s_in = 1'b1; dir = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (cycles == trace_step) begin
                n_checks++;
                if ({a_out, b_out} !== trace_ab || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL trace_step%0d: got a=%h b=%h busy=%b expected a=%h b=%h busy=1",
                             cycles, a_out, b_out, busy, trace_ab[2*W-1:W], trace_ab[W-1:0]);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (cycles != 24) begin
            n_fail++;
            $display("FAIL latency: got %0d edges expected 24", cycles);
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            if (a_out !== e.a || b_out !== e.b || s_out !== e.s || x_out !== e.x) begin
                n_fail++;
                $display("FAIL result: got a=%h b=%h s=%b x=%h expected a=%h b=%h s=%b x=%h",
                         a_out, b_out, s_out, x_out, e.a, e.b, e.s, e.x);
            end
        end
        snap = {a_out, b_out, x_out, s_out};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_out, b_out, x_out, s_out} !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got out_valid=%b in_ready=%b a=%h b=%h expected 1 0 %h %h",
                         i, out_valid, in_ready, a_out, b_out, snap[3*W:2*W+1], snap[2*W:W+1]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dir = 1'b0;
        a_in = '0; b_in = '0; x_in = '0; s_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            a_out !== '0 || b_out !== '0 || x_out !== '0 || s_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b ov=%b busy=%b a=%h b=%h x=%h s=%b expected all 0",
                     in_ready, out_valid, busy, a_out, b_out, x_out, s_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_forward();
        start_op(12'h0F0, 12'h123, 1'b1, 12'hAAA, 1'b0);
        finish_op(2, {12'h0F2, 12'h123}, -1, 0);
        start_op(12'h0F0, 12'h123, 1'b0, 12'hAAA, 1'b0);
        finish_op(14, {12'h0F0, 12'h121}, -1, 0);
    endtask

    task automatic test_reverse_order();
        start_op(12'h0F0, 12'h123, 1'b0, 12'hAAA, 1'b1);
        finish_op(1, {12'h0F0, 12'h923}, -1, 0);
        start_op(12'h0F0, 12'h123, 1'b1, 12'hAAA, 1'b1);
        finish_op(13, {12'h8F0, 12'h123}, -1, 0);
    endtask

    task automatic test_round_trip();
        logic [W-1:0] a, b, x, fa, fb;
        logic         s;
        start_op(12'h0F0, 12'h123, 1'b1, 12'hAAA, 1'b0);
        finish_op(-1, '0, -1, 0);
        start_op(a_out, b_out, 1'b1, 12'hAAA, 1'b1);
        finish_op(-1, '0, -1, 0);
        n_checks++;
        if (a_out !== 12'h0F0 || b_out !== 12'h123) begin
            n_fail++;
            $display("FAIL round_trip_case2: got a=%h b=%h expected a=0f0 b=123", a_out, b_out);
        end
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom); b = W'($urandom); x = W'($urandom); s = 1'($urandom);
            start_op(a, b, s, x, 1'b0);
            finish_op(-1, '0, -1, 0);
            fa = a_out; fb = b_out;
            start_op(fa, fb, s, x, 1'b1);
            finish_op(-1, '0, -1, 0);
            n_checks++;
            if (a_out !== a || b_out !== b) begin
                n_fail++;
                $display("FAIL round_trip_%0d: got a=%h b=%h expected a=%h b=%h", i, a_out, b_out, a, b);
            end
        end
    endtask

    task automatic test_handshake();
        start_op(12'h3C5, 12'h9E1, 1'b1, 12'h5F0, 1'b0);
        finish_op(-1, '0, 5, 10);
    endtask

    task automatic test_back_to_back();
        int cycles;
        res_t e;
        start_op(12'h111, 12'h222, 1'b0, 12'h0FF, 1'b0);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_scoreboard: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            if (out_valid !== 1'b1 || a_out !== e.a || b_out !== e.b) begin
                n_fail++;
                $display("FAIL b2b_first: got ov=%b a=%h b=%h expected 1 %h %h",
                         out_valid, a_out, b_out, e.a, e.b);
            end
        end
        out_ready = 1'b1; in_valid = 1'b1;
        a_in = 12'hABC; b_in = 12'hDEF; s_in = 1'b1; x_in = 12'h0F0; dir = 1'b1;
        e.a = 12'hABC ^ 12'h0F0; e.b = 12'hDEF; e.s = 1'b1; e.x = 12'h0F0;
        sb_q.push_back(e);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_priority: got ov=%b rdy=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
        end
        finish_op(-1, '0, -1, 0);
    endtask

    task automatic test_reset_mid_op();
        logic rose;
        res_t e;
        start_op(12'h5A5, 12'hA5A, 1'b1, 12'hFFF, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        if (sb_q.size() != 0) e = sb_q.pop_back();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
            a_out !== '0 || b_out !== '0 || x_out !== '0 || s_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got busy=%b ov=%b rdy=%b a=%h b=%h x=%h s=%b expected all 0",
                     busy, out_valid, in_ready, a_out, b_out, x_out, s_out);
        end
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) rose = 1'b1;
        end
        n_checks++;
        if (rose !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_no_result: got rose=%b in_ready=%b expected 0 1", rose, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_order();
        test_handshake();
        test_back_to_back();
        test_round_trip();
        test_reset_mid_op();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
